// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU memory responder: FSM states, latched request record, write-enable idle value.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DM_ACC = 2'd1,
    IM_ACC = 2'd2,
    RESP   = 2'd3
  } bus_state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_kind_t;

  localparam logic [3:0] WEB_NONE = 4'hF;
  localparam int         WAIT_W   = 4;

  typedef struct packed {
    req_kind_t   kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  web;
  } req_t;

  // A store wins over a load when both strobes are raised together.
  function automatic req_kind_t dm_kind(input logic rd, input logic wr);
    if (wr)      return REQ_WRITE;
    else if (rd) return REQ_READ;
    else         return REQ_NONE;
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Load/decrement down-counter timing one SRAM access; zero marks the final access cycle.
// Loading takes priority over decrementing; the count holds at zero.
module bus_wait_counter
  import cpu_bus_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cpu_mem_responder.sv
// Serves CPU fetch and data requests from one single-ported SRAM, DM before IM, WAIT_CYCLES+1 cycles each,
// freezing the CPU via bus_stall. Optional perf counters under `BUS_PERF_CNT_EN.
module cpu_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_read_mem,
  input  logic [31:0]       im_addr,
  input  logic              dm_read_mem,
  input  logic              dm_write_mem,
  input  logic [3:0]        dm_web,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_datain,
  output logic [31:0]       im_dataout,
  output logic [31:0]       dm_dataout,
  output logic              bus_stall,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [31:0]       sram_di,
  input  logic [31:0]       sram_do,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_acc_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

  bus_state_t state, state_nxt;
  req_t       dm_req, im_req;
  logic       any_req, dm_any;
  logic       latch_req;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic       acc_done;
  logic       unused_bits;

  assign dm_any  = dm_read_mem | dm_write_mem;
  assign any_req = dm_any | im_read_mem;

  bus_wait_counter #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WAIT_LD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus_stall = 1'b0;
    sram_cs   = 1'b0;
    sram_oe   = 1'b0;
    sram_web  = WEB_NONE;
    sram_a    = '0;
    sram_di   = '0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    latch_req = 1'b0;
    acc_done  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          bus_stall = 1'b1;
          latch_req = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = dm_any ? DM_ACC : IM_ACC;
        end
      end
      DM_ACC: begin
        bus_stall = 1'b1;
        sram_cs   = 1'b1;
        sram_a    = dm_req.addr[ADDR_W+1:2];
        if (dm_req.kind == REQ_WRITE) begin
          sram_di = dm_req.data;
          // Byte enables only in the final cycle so a mid-access abort never commits.
          if (cnt_zero) sram_web = dm_req.web;
        end else begin
          sram_oe = 1'b1;
        end
        if (cnt_zero) begin
          acc_done = 1'b1;
          if (im_req.kind != REQ_NONE) begin
            cnt_load  = 1'b1;
            state_nxt = IM_ACC;
          end else begin
            state_nxt = RESP;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      IM_ACC: begin
        bus_stall = 1'b1;
        sram_cs   = 1'b1;
        sram_oe   = 1'b1;
        sram_a    = im_req.addr[ADDR_W+1:2];
        if (cnt_zero) begin
          acc_done  = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      bus_stall = 1'b0;
      sram_web  = WEB_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req <= '{kind: REQ_NONE, addr: '0, data: '0, web: WEB_NONE};
      im_req <= '{kind: REQ_NONE, addr: '0, data: '0, web: WEB_NONE};
    end else if (latch_req) begin
      dm_req <= '{kind: dm_kind(dm_read_mem, dm_write_mem), addr: dm_addr,
                  data: dm_datain, web: dm_web};
      im_req <= '{kind: (im_read_mem ? REQ_READ : REQ_NONE), addr: im_addr,
                  data: '0, web: WEB_NONE};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_dataout <= '0;
      im_dataout <= '0;
    end else begin
      if ((state == DM_ACC) && cnt_zero && (dm_req.kind == REQ_READ)) begin
        dm_dataout <= sram_do;
      end
      if ((state == IM_ACC) && cnt_zero) begin
        im_dataout <= sram_do;
      end
    end
  end

  // Byte-offset and out-of-range address bits are deliberately dropped.
  assign unused_bits = ^{dm_req.addr[31:ADDR_W+2], dm_req.addr[1:0],
                         im_req.addr[31:ADDR_W+2], im_req.addr[1:0],
                         im_req.data, im_req.web};

`ifdef BUS_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_acc_cnt   <= '0;
    end else begin
      if (bus_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (acc_done && (perf_acc_cnt != 32'hFFFF_FFFF)) begin
        perf_acc_cnt <= perf_acc_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_acc_done;
  assign unused_acc_done = acc_done;
  assign perf_stall_cnt  = 32'd0;
  assign perf_acc_cnt    = 32'd0;
`endif

endmodule
